// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: merges load-use, taken-branch and
// mul/div hazards into per-stage enables/flushes, sequences mul/div, counts stalls/flushes.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       exe_rd,
    input  logic             exe_ltype,
    input  logic             exe_md,
    input  logic             exe_branch_taken,
    input  logic             md_done,
    output logic             md_start,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic             flush_evt;

    always_comb begin
        load_use = exe_ltype && (exe_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == exe_rd)) ||
                    (id_use_rs2 && (id_rs2 == exe_rd)));
    end

    always_comb begin
        state_d     = state_q;
        md_start    = 1'b0;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        flush_evt   = 1'b0;

        case (state_q)
            RUN: begin
                if (exe_md) begin
                    md_start    = 1'b1;
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                    state_d     = MD_BUSY;
                end else if (exe_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_evt  = 1'b1;
                end else if (load_use) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            MD_BUSY: begin
                // Hold the mul/div op in EX and feed bubbles downstream until its result lands.
                if (!md_done) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_flush = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (rst) begin
            state_d     = RUN;
            md_start    = 1'b0;
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_evt   = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_evt) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign md_busy   = (state_q == MD_BUSY);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (CNT_W=4): hazard priorities, mul/div sequencing,
// reset behaviour and counter wrap, with hand-computed control vectors.
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_rs1, id_rs2, exe_rd;
    logic             id_use_rs1, id_use_rs2;
    logic             exe_ltype, exe_md, exe_branch_taken, md_done;
    logic             md_start, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic             exmem_flush, md_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // {md_start, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, md_busy}
    localparam logic [7:0] C_DEF     = 8'b0110_1000;
    localparam logic [7:0] C_RST_RUN = 8'b0111_1110;
    localparam logic [7:0] C_RST_MD  = 8'b0111_1111;
    localparam logic [7:0] C_LU      = 8'b0000_1100;
    localparam logic [7:0] C_BR      = 8'b0111_1100;
    localparam logic [7:0] C_MDSTART = 8'b1000_0010;
    localparam logic [7:0] C_MDWAIT  = 8'b0000_0011;
    localparam logic [7:0] C_MDDONE  = 8'b0110_1001;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .exe_rd(exe_rd), .exe_ltype(exe_ltype), .exe_md(exe_md),
        .exe_branch_taken(exe_branch_taken), .md_done(md_done),
        .md_start(md_start), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .md_busy(md_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    wire [7:0] ctl = {md_start, pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                      exmem_flush, md_busy};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        exe_rd = 5'd0; exe_ltype = 1'b0; exe_md = 1'b0;
        exe_branch_taken = 1'b0; md_done = 1'b0;
    endtask

    task automatic set_load_use_rs1(input logic [4:0] r);
        exe_ltype = 1'b1; exe_rd = r; id_rs1 = r; id_use_rs1 = 1'b1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        sample();
        chk("reset_ctl", 32'(ctl), 32'(C_RST_RUN));
        advance();

        rst = 1'b0;
        sample();
        chk("idle_ctl", 32'(ctl), 32'(C_DEF));
        chk("idle_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("idle_flush_cnt", 32'(flush_cnt), 32'd0);
        advance();

        // Load-use on rs1
        set_load_use_rs1(5'd5);
        sample();
        chk("lu_rs1_ctl", 32'(ctl), 32'(C_LU));
        advance();
        clear_inputs();
        sample();
        chk("lu_release_ctl", 32'(ctl), 32'(C_DEF));
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        advance();

        // Load-use on rs2
        exe_ltype = 1'b1; exe_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        sample();
        chk("lu_rs2_ctl", 32'(ctl), 32'(C_LU));
        advance();

        // rd = x0 never stalls
        clear_inputs();
        set_load_use_rs1(5'd0);
        sample();
        chk("lu_x0_ctl", 32'(ctl), 32'(C_DEF));
        chk("lu_x0_stall_cnt", 32'(stall_cnt), 32'd2);
        advance();

        // Matching register but not read
        clear_inputs();
        exe_ltype = 1'b1; exe_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
        sample();
        chk("lu_unused_ctl", 32'(ctl), 32'(C_DEF));
        advance();

        // Branch beats load-use
        clear_inputs();
        set_load_use_rs1(5'd5);
        exe_branch_taken = 1'b1;
        sample();
        chk("br_ctl", 32'(ctl), 32'(C_BR));
        advance();
        clear_inputs();
        sample();
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd2);
        advance();

        // Spurious md_done in RUN
        md_done = 1'b1;
        sample();
        chk("spur_done_ctl", 32'(ctl), 32'(C_DEF));
        advance();
        md_done = 1'b0;
        sample();
        chk("spur_done_after", 32'(ctl), 32'(C_DEF));
        advance();

        // Mul/div, done 3 cycles after start; a coincident branch must lose to exe_md
        exe_md = 1'b1; exe_branch_taken = 1'b1;
        sample();
        chk("md_c0_ctl", 32'(ctl), 32'(C_MDSTART));
        advance();
        exe_branch_taken = 1'b0;
        sample();
        chk("md_c1_ctl", 32'(ctl), 32'(C_MDWAIT));
        chk("md_c1_flush_cnt", 32'(flush_cnt), 32'd1);
        advance();
        sample();
        chk("md_c2_ctl", 32'(ctl), 32'(C_MDWAIT));
        advance();
        md_done = 1'b1;
        exe_branch_taken = 1'b1;
        set_load_use_rs1(5'd9);
        sample();
        chk("md_c3_ctl", 32'(ctl), 32'(C_MDDONE));
        advance();
        clear_inputs();
        sample();
        chk("md_after_ctl", 32'(ctl), 32'(C_DEF));
        chk("md_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("md_flush_cnt", 32'(flush_cnt), 32'd1);
        advance();

        // Reset in the second MD_BUSY cycle
        exe_md = 1'b1;
        sample();
        chk("mdr_c0_ctl", 32'(ctl), 32'(C_MDSTART));
        advance();
        sample();
        chk("mdr_c1_ctl", 32'(ctl), 32'(C_MDWAIT));
        advance();
        rst = 1'b1;
        sample();
        chk("mdr_rst_ctl", 32'(ctl), 32'(C_RST_MD));
        advance();
        rst = 1'b0;
        exe_md = 1'b0;
        sample();
        chk("mdr_after_ctl", 32'(ctl), 32'(C_DEF));
        chk("mdr_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("mdr_flush_cnt", 32'(flush_cnt), 32'd0);
        advance();

        // 17 stall cycles wrap a 4-bit counter to 1
        set_load_use_rs1(5'd3);
        for (int i = 0; i < 17; i++) begin
            advance();
        end
        clear_inputs();
        sample();
        chk("wrap_stall_cnt", 32'(stall_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush scheduler for the 5-stage pipelined CPU. Combines load-use hazards (ID vs. EX load), taken branches/jumps resolved in EX, and the multi-cycle mul/div unit in EX into one set of per-stage enable and flush controls. It sequences the mul/div unit with a start/done handshake and keeps stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- id_rs1  input  5  rs1 field of instruction in ID
- id_rs2  input  5  rs2 field of instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- exe_rd  input  5  rd of instruction in EX
- exe_ltype  input  1  EX instruction is a load
- exe_md  input  1  EX instruction is mul/div
- exe_branch_taken  input  1  EX branch/jump resolved taken
- md_done  input  1  mul/div result valid (1-cycle pulse)
- md_start  output  1  start pulse to mul/div unit
- pc_en  output  1  PC register load enable
- ifid_en  output  1  IF/ID register enable
- ifid_flush  output  1  IF/ID clear to NOP
- idex_en  output  1  ID/EX register enable
- idex_flush  output  1  ID/EX clear to NOP
- exmem_flush  output  1  EX/MEM clear to NOP
- md_busy  output  1  FSM in MD_BUSY
- stall_cnt  output  CNT_W  cycles with pc_en=0
- flush_cnt  output  CNT_W  taken-branch flush events

## Operation
- FSM states: RUN, MD_BUSY. Reset state RUN.
- Default outputs (no event): all enables 1, all flushes 0, md_start 0.
- load_use = exe_ltype & (exe_rd != 0) & ((id_use_rs1 & id_rs1 == exe_rd) | (id_use_rs2 & id_rs2 == exe_rd)). rd = x0 never stalls.
- RUN, priority high to low:
  - exe_md=1: md_start=1, pc_en=ifid_en=idex_en=0, exmem_flush=1; next MD_BUSY.
  - exe_branch_taken=1: ifid_flush=1, idex_flush=1, pc_en=1 (PC loads target); load_use ignored.
  - load_use=1: pc_en=0, ifid_en=0, idex_flush=1 (bubble into EX).
- MD_BUSY:
  - md_done=0: pc_en=ifid_en=idex_en=0, exmem_flush=1; stay.
  - md_done=1: all enables 1, exmem_flush=0 (result captured into EX/MEM); next RUN. exe_branch_taken and load_use ignored this cycle.
- md_done in RUN is ignored. md_start never asserted in MD_BUSY.
- exe_md, exe_ltype, exe_branch_taken are mutually exclusive from decode; if several are set, priority above applies.
- md_busy = (state == MD_BUSY).
- Counters: stall_cnt +1 each non-reset cycle with pc_en=0; flush_cnt +1 each non-reset cycle in RUN with exe_branch_taken=1 and exe_md=0. Both wrap modulo 2^CNT_W.

## Timing
- All control outputs combinational from state and inputs, valid in the same cycle. State and counters update on the rising clk edge.
- Load-use stall: exactly 1 cycle; next cycle the load is in MEM, so load_use deasserts.
- Mul/div: md_start is a 1-cycle pulse in the cycle the op enters EX; the unit asserts md_done no earlier than the following cycle. The front end is frozen for N+1 cycles, where N is the number of MD_BUSY cycles before md_done.
- rst=1 (any state, including mid-MD_BUSY): next state RUN; stall_cnt=flush_cnt=0; during the reset cycle md_start=0, pc_en=ifid_en=idex_en=1, ifid_flush=idex_flush=exmem_flush=1, md_busy follows state. Counters do not increment in reset cycles. The mul/div unit is reset separately; no md_start is reissued.

## Test plan
- Load-use: exe_ltype=1, exe_rd=5, id_rs1=5, id_use_rs1=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; stall_cnt 0->1; exe_rd=0 with the same operands -> no stall.
- Branch beats load-use: exe_branch_taken=1 with a load_use match -> ifid_flush=idex_flush=1, pc_en=1; flush_cnt +1; stall_cnt unchanged.
- Mul/div with md_done 3 cycles after start -> md_start high only in cycle 0; md_busy high in cycles 1-3; pc_en=0 in cycles 0-2; cycle 3 has all enables 1 and exmem_flush=0; stall_cnt +3.
- Spurious md_done in RUN with no exe_md -> no state change, default outputs.
- Reset asserted in the second MD_BUSY cycle -> next cycle in RUN, md_busy=0, counters 0, md_start=0.
- Counter wrap with CNT_W=4: 17 load-use stall cycles -> stall_cnt=1.
